keypad_regfile_alu: RTL and testbench

- Parametrised successor to the keypad/register-bank/ALU datapath.
- Integrates three functions:
  - a self-timed 4x4 keypad column scanner with sweep-level debounce;
  - an NREGS x WIDTH register file loaded by nibble shift-in from the keypad;
  - a two-stage sequenced ALU with start/busy/done handshake, registered flags and optional write-back.
- Sits directly behind the top-level pin wrapper.

---
 rtl/keypad_regfile_alu.sv | 241 ++++++++++++++++++++++++
 tb/tb_keypad_regfile_alu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_regfile_alu.sv
// Keypad column scanner with sweep debounce, nibble-loaded register file and a sequenced ALU.
// Latency: start->done 3 cycles; key accepted at sweep end; dbg_data 1 cycle after address.
// Backpressure: start is ignored while busy; key loads to the register being written back are dropped.
module keypad_regfile_alu #(
  parameter int WIDTH    = 8,
  parameter int NREGS    = 4,
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 3,
  localparam int ADDR_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        row_in,
  output logic [1:0]        col_sel,
  input  logic              key_wr_en,
  input  logic [ADDR_W-1:0] key_addr,
  output logic [3:0]        key_code,
  output logic              key_strobe,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic              wb_en,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [3:0]        flags,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;

  typedef struct packed {
    logic [2:0]        alu_op;
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] rd;
    logic              wb;
  } cmd_t;

  // ---------------- scanner ----------------
  logic [DIV_W-1:0] dwell;
  logic             dwell_tc;
  logic             sweep_end;
  logic             row_hit;
  logic [1:0]       row_idx;
  logic             acc_hit;
  logic [3:0]       acc_code;
  logic             sweep_hit;
  logic [3:0]       sweep_code;
  logic [4:0]       sweep_key;

  assign dwell_tc  = (dwell == DIV_W'(SCAN_DIV - 1));
  assign sweep_end = dwell_tc && (col_sel == 2'd3);

  // Lowest asserted row wins within one column sample.
  always_comb begin
    row_hit = |row_in;
    row_idx = 2'd0;
    if (row_in[0])      row_idx = 2'd0;
    else if (row_in[1]) row_idx = 2'd1;
    else if (row_in[2]) row_idx = 2'd2;
    else if (row_in[3]) row_idx = 2'd3;
  end

  // Sweep key so far including the current sample; column 0 starts a fresh sweep.
  always_comb begin
    if ((col_sel != 2'd0) && acc_hit) begin
      sweep_hit  = 1'b1;
      sweep_code = acc_code;
    end else begin
      sweep_hit  = row_hit;
      sweep_code = {col_sel, row_idx};
    end
    sweep_key = {sweep_hit, sweep_hit ? sweep_code : 4'h0};
  end

  // Column dwell counter and per-sweep accumulation of the first hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell    <= '0;
      col_sel  <= 2'd0;
      acc_hit  <= 1'b0;
      acc_code <= 4'h0;
    end else if (dwell_tc) begin
      dwell    <= '0;
      col_sel  <= col_sel + 2'd1;
      acc_hit  <= sweep_hit;
      acc_code <= sweep_code;
    end else begin
      dwell <= dwell + DIV_W'(1);
    end
  end

  // ---------------- debounce ----------------
  logic [4:0]       prev_key;
  logic [DEB_W-1:0] stable;
  logic [DEB_W-1:0] stable_nxt;
  logic             armed;

  // Count consecutive identical sweeps, saturating at DEBOUNCE.
  always_comb begin
    if (sweep_key == prev_key)
      stable_nxt = (stable == DEB_W'(DEBOUNCE)) ? stable : stable + DEB_W'(1);
    else
      stable_nxt = DEB_W'(1);
  end

  // Accept a key once it is stable and armed; only an empty sweep re-arms.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_key   <= 5'd0;
      stable     <= '0;
      armed      <= 1'b1;
      key_strobe <= 1'b0;
      key_code   <= 4'h0;
    end else begin
      key_strobe <= 1'b0;
      if (sweep_end) begin
        prev_key <= sweep_key;
        stable   <= stable_nxt;
        if (!sweep_hit) begin
          armed <= 1'b1;
        end else if ((stable_nxt == DEB_W'(DEBOUNCE)) && armed) begin
          key_strobe <= 1'b1;
          key_code   <= sweep_code;
          armed      <= 1'b0;
        end
      end
    end
  end

  // ---------------- ALU sequencer ----------------
  logic [1:0]       state;
  cmd_t             cmd;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             wb_fire;

  assign wb_fire = (state == S_EXEC) && cmd.wb;

  // Result and carry/overflow for the latched op on the captured operands.
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (cmd.alu_op)
      3'd0: begin
        ext     = {1'b0, opa} + {1'b0, opb};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      3'd1: begin
        ext     = {1'b0, opa} - {1'b0, opb};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
        alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (alu_res[WIDTH-1] != opa[WIDTH-1]);
      end
      3'd2: alu_res = opa & opb;
      3'd3: alu_res = opa | opb;
      3'd4: alu_res = opa ^ opb;
      3'd5: begin
        alu_res = {opa[WIDTH-2:0], 1'b0};
        alu_c   = opa[WIDTH-1];
      end
      3'd6: begin
        alu_res = {1'b0, opa[WIDTH-1:1]};
        alu_c   = opa[0];
      end
      default: alu_res = opa;
    endcase
  end

  // IDLE -> READ -> EXEC; reset aborts the op before any write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cmd    <= '0;
      opa    <= '0;
      opb    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flags  <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cmd   <= '{alu_op: op, ra: addr_a, rb: addr_b, rd: addr_d, wb: wb_en};
            busy  <= 1'b1;
            state <= S_READ;
          end
        end
        S_READ: begin
          opa   <= regs[cmd.ra];
          opb   <= regs[cmd.rb];
          state <= S_EXEC;
        end
        S_EXEC: begin
          result <= alu_res;
          flags  <= {alu_res[WIDTH-1], alu_v, alu_c, (alu_res == '0)};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------- register file ----------------
  // Key nibble shift-in and ALU write-back; write-back wins on the same register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      dbg_data <= '0;
    end else begin
      dbg_data <= regs[dbg_addr];
      if (key_strobe && key_wr_en && !(wb_fire && (cmd.rd == key_addr)))
        regs[key_addr] <= {regs[key_addr][WIDTH-5:0], key_code};
      if (wb_fire)
        regs[cmd.rd] <= alu_res;
    end
  end

endmodule

// File: tb/tb_keypad_regfile_alu.sv
// Randomised bench for two keypad_regfile_alu builds (8-bit/4 regs and 16-bit/8 regs).
// Latency: reference model advances once per rising edge; outputs sampled 1 time unit later.
// Backpressure: stimulus may pulse start while busy; the model decides what is accepted.
module tb_keypad_regfile_alu;

  localparam int SD  = 16;
  localparam int DB  = 3;
  localparam int SWP = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in;
  logic        key_wr_en;
  logic [2:0]  key_addr;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  addr_a, addr_b, addr_d, dbg_addr;
  logic        wb_en;

  logic [1:0]  col8, col16;
  logic [3:0]  kc8, kc16;
  logic        ks8, ks16;
  logic        busy8, busy16, done8, done16;
  logic [7:0]  res8, dbg8;
  logic [15:0] res16, dbg16;
  logic [3:0]  fl8, fl16;

  always #5 clk = ~clk;

  keypad_regfile_alu #(.WIDTH(8), .NREGS(4), .SCAN_DIV(SD), .DEBOUNCE(DB)) u_w8 (
    .clk(clk), .reset(rst), .row_in(row_in), .col_sel(col8),
    .key_wr_en(key_wr_en), .key_addr(key_addr[1:0]), .key_code(kc8), .key_strobe(ks8),
    .start(start), .op(op), .addr_a(addr_a[1:0]), .addr_b(addr_b[1:0]), .addr_d(addr_d[1:0]),
    .wb_en(wb_en), .busy(busy8), .done(done8), .result(res8), .flags(fl8),
    .dbg_addr(dbg_addr[1:0]), .dbg_data(dbg8)
  );

  keypad_regfile_alu #(.WIDTH(16), .NREGS(8), .SCAN_DIV(SD), .DEBOUNCE(DB)) u_w16 (
    .clk(clk), .reset(rst), .row_in(row_in), .col_sel(col16),
    .key_wr_en(key_wr_en), .key_addr(key_addr), .key_code(kc16), .key_strobe(ks16),
    .start(start), .op(op), .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
    .wb_en(wb_en), .busy(busy16), .done(done16), .result(res16), .flags(fl16),
    .dbg_addr(dbg_addr), .dbg_data(dbg16)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int     k;
  int     samp_row [4];
  int     prev_key, stable;
  bit     armed;
  bit     exp_strobe;
  int     exp_code;
  longint mregs [2][8];
  int     phase;
  int     c_op, c_a, c_b, c_d;
  bit     c_wb;
  longint opa [2], opb [2];
  longint exp_res [2], exp_dbg [2];
  int     exp_flags [2];
  bit     exp_busy, exp_done;

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic int nreg(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic int first_row(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic alu_model(input int w, input int opc, input longint a, input longint b,
                           output longint res, output int fl);
    longint full, half, mask, sa, sb, ss;
    int c, v, n, z;
    full = longint'(1) << w;
    half = longint'(1) << (w - 1);
    mask = full - 1;
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    c = 0; v = 0;
    case (opc)
      0: begin res = (a + b) & mask; c = int'((a + b) >= full); ss = sa + sb; v = int'(ss < -half || ss >= half); end
      1: begin res = (a - b) & mask; c = int'(a < b); ss = sa - sb; v = int'(ss < -half || ss >= half); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a * 2) & mask; c = int'(a >= half); end
      6: begin res = a / 2; c = int'(a % 2); end
      default: res = a;
    endcase
    n = int'(res >= half);
    z = int'(res == 0);
    fl = n * 8 + v * 4 + c * 2 + z;
  endtask

  task automatic model_reset();
    k = 0;
    for (int c = 0; c < 4; c++) samp_row[c] = -1;
    prev_key = -1; stable = 0; armed = 1'b1;
    exp_strobe = 1'b0; exp_code = 0;
    phase = 0; exp_busy = 1'b0; exp_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 8; r++) mregs[i][r] = 0;
      exp_res[i] = 0; exp_flags[i] = 0; exp_dbg[i] = 0; opa[i] = 0; opb[i] = 0;
    end
  endtask

  task automatic model_edge();
    longint old [2][8];
    bit     strobe_was, wb_do;
    int     code_was, pos, col, kk, ka, da;
    longint r;
    int     f;
    if (rst) begin
      model_reset();
      return;
    end
    old = mregs;
    strobe_was = exp_strobe;
    code_was   = exp_code;
    exp_strobe = 1'b0;
    exp_done   = 1'b0;
    wb_do      = 1'b0;
    for (int i = 0; i < 2; i++) exp_dbg[i] = old[i][int'(dbg_addr) % nreg(i)];
    if (phase == 0) begin
      if (start) begin
        c_op = int'(op); c_a = int'(addr_a); c_b = int'(addr_b); c_d = int'(addr_d); c_wb = wb_en;
        phase = 1; exp_busy = 1'b1;
      end
    end else if (phase == 1) begin
      for (int i = 0; i < 2; i++) begin
        opa[i] = old[i][c_a % nreg(i)];
        opb[i] = old[i][c_b % nreg(i)];
      end
      phase = 2;
    end else begin
      for (int i = 0; i < 2; i++) begin
        alu_model(wid(i), c_op, opa[i], opb[i], r, f);
        exp_res[i] = r; exp_flags[i] = f;
      end
      exp_done = 1'b1; exp_busy = 1'b0; phase = 0; wb_do = c_wb;
    end
    for (int i = 0; i < 2; i++) begin
      ka = int'(key_addr) % nreg(i);
      da = c_d % nreg(i);
      if (strobe_was && key_wr_en && !(wb_do && da == ka))
        mregs[i][ka] = ((old[i][ka] * 16) + code_was) & ((longint'(1) << wid(i)) - 1);
      if (wb_do) mregs[i][da] = exp_res[i];
    end
    pos = k % SD;
    col = (k / SD) % 4;
    if (pos == SD - 1) begin
      samp_row[col] = first_row(row_in);
      if (col == 3) begin
        kk = -1;
        for (int c = 0; c < 4; c++) begin
          if (samp_row[c] >= 0) begin
            kk = c * 4 + samp_row[c];
            break;
          end
        end
        stable = (kk == prev_key) ? ((stable < DB) ? stable + 1 : DB) : 1;
        prev_key = kk;
        if (kk < 0) armed = 1'b1;
        else if (stable == DB && armed) begin
          exp_strobe = 1'b1; exp_code = kk; armed = 1'b0;
        end
      end
    end
    k++;
  endtask

  task automatic compare_all();
    chk("col_sel8",  32'(col8),  32'((k / SD) % 4));
    chk("col_sel16", 32'(col16), 32'((k / SD) % 4));
    chk("key_strobe8",  32'(ks8),  32'(exp_strobe));
    chk("key_strobe16", 32'(ks16), 32'(exp_strobe));
    chk("key_code8",  32'(kc8),  32'(exp_code));
    chk("key_code16", 32'(kc16), 32'(exp_code));
    chk("busy8",  32'(busy8),  32'(exp_busy));
    chk("busy16", 32'(busy16), 32'(exp_busy));
    chk("done8",  32'(done8),  32'(exp_done));
    chk("done16", 32'(done16), 32'(exp_done));
    chk("result8",  32'(res8),  32'(exp_res[0]));
    chk("result16", 32'(res16), 32'(exp_res[1]));
    chk("flags8",  32'(fl8),  32'(exp_flags[0]));
    chk("flags16", 32'(fl16), 32'(exp_flags[1]));
    chk("dbg_data8",  32'(dbg8),  32'(exp_dbg[0]));
    chk("dbg_data16", 32'(dbg16), 32'(exp_dbg[1]));
  endtask

  // ---------------- stimulus ----------------
  int plan_key  = -1;
  int plan_left = 0;
  bit plan_hold = 1'b0;

  task automatic drive_inputs(input int cyc);
    int pos, col, pc, pr;
    pos = k % SD;
    col = (k / SD) % 4;
    rst = (cyc < 3) || (phase == 1 && $urandom_range(0, 15) == 0) || ($urandom_range(0, 3999) == 0);
    if (k % SWP == 0) begin
      if (plan_left == 0) begin
        plan_hold = !plan_hold;
        if (plan_hold) begin
          plan_key  = $urandom_range(0, 15);
          plan_left = $urandom_range(1, 5);
        end else begin
          plan_key  = -1;
          plan_left = $urandom_range(1, 2);
        end
      end
      plan_left--;
      key_addr = 3'($urandom_range(0, 7));
    end
    if (pos == SD - 1) begin
      row_in = 4'h0;
      if (plan_key >= 0) begin
        pc = plan_key / 4;
        pr = plan_key % 4;
        if (col == pc) row_in = 4'((1 << pr) | ($urandom_range(0, 15) & ~((2 << pr) - 1)));
        else if (col > pc) row_in = 4'($urandom_range(0, 15));
      end
    end else begin
      row_in = 4'($urandom_range(0, 15));
    end
    key_wr_en = ($urandom_range(0, 3) != 0);
    op        = 3'($urandom_range(0, 7));
    addr_a    = 3'($urandom_range(0, 7));
    addr_b    = 3'($urandom_range(0, 7));
    dbg_addr  = 3'($urandom_range(0, 7));
    if (k % SWP == SWP - 2 && $urandom_range(0, 1) == 1) begin
      start  = 1'b1;
      addr_d = key_addr;
      wb_en  = 1'b1;
    end else begin
      start  = ($urandom_range(0, 5) == 0);
      addr_d = 3'($urandom_range(0, 7));
      wb_en  = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    rst = 1'b1; row_in = 4'h0; key_wr_en = 1'b0; key_addr = 3'd0; start = 1'b0;
    op = 3'd0; addr_a = 3'd0; addr_b = 3'd0; addr_d = 3'd0; wb_en = 1'b0; dbg_addr = 3'd0;
    model_reset();
    for (int cyc = 0; cyc < 300 * SWP && n_err < 200; cyc++) begin
      @(negedge clk);
      drive_inputs(cyc);
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
